rv32i_pc_rf_alu: RTL and testbench
==================================

Name: rv32i_pc_rf_alu

Overview:
- Bundles the three core datapath primitives of the pipelined RV32I core: program-counter register, 32x32 integer register file and combinational ALU.
- PC feeds instruction fetch (IF). The register file is read in decode (ID) and written from writeback (WB). The ALU serves execute (EX) and produces the branch-condition flag used for next-PC selection.
- No pipeline registers or hazard logic inside; those stay in the surrounding core.

Parameters:
- XLEN, 32, datapath width (only 32 supported).
- RESET_PC, 32'h0000_0000, PC value loaded on reset.

Ports:
- clk  input  1  single system clock, rising-edge active.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- pc_stall  input  1  1 = hold PC (stallF); 0 = load pc_next.
- pc_next  input  32  next-PC value (PC+4 or branch/jump target, selected externally).
- pc  output  32  current fetch address.
- rf_we  input  1  register write enable (WB stage).
- rf_waddr  input  5  write register index.
- rf_wdata  input  32  write data (WB result).
- rf_raddr1  input  5  read port 1 index (rs1).
- rf_raddr2  input  5  read port 2 index (rs2).
- rf_rdata1  output  32  read port 1 data.
- rf_rdata2  output  32  read port 2 data.
- alu_a  input  32  operand A (forwarded rs1).
- alu_b  input  32  operand B (forwarded rs2 or immediate).
- alu_op  input  4  operation select.
- alu_u_s  input  1  1 = unsigned compare; 0 = signed.
- alu_result  output  32  ALU result.
- alu_zero  output  1  condition flag (see below).

Behaviour:
- PC:
  - reset low: pc = RESET_PC immediately (async).
  - Rising edge with reset high: pc <= pc_next if pc_stall = 0, otherwise pc holds.
  - No alignment check; value is stored verbatim.
- RF:
  - 32 entries x 32 bits.
  - reset low: all entries cleared to 0 (async).
  - Write at rising edge when rf_we = 1 and rf_waddr != 0. Writes to x0 are ignored; x0 always reads 0.
  - Reads are combinational.
  - Write-through bypass: if rf_we = 1, rf_waddr != 0 and rf_waddr equals a read address, that port returns rf_wdata in the same cycle. WB-to-ID needs no external forwarding.
  - Both read ports may address the same register.
- ALU (purely combinational, zero latency; shift amount = alu_b[4:0]):
  - 0 ADD: a+b, wraps mod 2^32.
  - 1 SUB: a-b, wraps.
  - 2 AND.
  - 3 OR.
  - 4 XOR.
  - 5 SLL.
  - 6 SRL: logical.
  - 7 SRA: arithmetic.
  - 8 SLT: result = {31'b0, a<b}; signed compare, unsigned when alu_u_s = 1.
  - 9 PASSB: result = b (LUI).
  - 10 BEQ: result = a-b.
  - 11 BNE: result = a-b.
  - 12 BLT: result = {31'b0, a<b}; signedness per alu_u_s.
  - 13 BGE: result = {31'b0, a>=b}; signedness per alu_u_s.
  - 14–15 reserved: result = 0.
- alu_zero:
  - ops 10–13: 1 when the branch condition holds (a==b, a!=b, a<b, a>=b respectively).
  - ops 0–9 and 14–15: 1 when alu_result == 0.
  - The core computes PC_src = (alu_zero & branch) | jump.
- alu_u_s affects only ops 8, 12 and 13.
- Reset has no effect on the ALU. During reset, RF reads return 0 (bypass still applies only when reset is high).

Decomposition:
- Shared package rv32i_pkg:
  - ALU op localparams ALU_ADD … ALU_BGE (4-bit).
  - XLEN.
  - RESET_PC default.
- One natural sub-module: rv32i_regfile (storage, x0 rule, bypass).
- PC register and ALU stay inline as always blocks in the top.

Test Plan:
- Reset/PC: assert reset, drive pc_next = 0x40 -> pc = 0x0. Release reset, pc_stall = 0 -> pc = 0x40 after 1 edge. pc_stall = 1, pc_next = 0x80 -> pc stays 0x40. Mid-run reset -> pc = 0x0 without waiting for a clock edge.
- RF: write x5 = 0xDEADBEEF, read x5 -> 0xDEADBEEF. Write x0 = 0x1234 -> x0 reads 0. Same-cycle write x7 = 0xA5A5A5A5 with raddr1 = 7 -> rdata1 = 0xA5A5A5A5 before the edge. Reset -> x5 reads 0.
- ALU arithmetic/shift: ADD 0xFFFFFFFF+1 -> 0, zero = 1. SUB 5-7 -> 0xFFFFFFFE. SRA 0x80000000 by 4 -> 0xF8000000. SRL same -> 0x08000000. SLL 1 by 31 -> 0x80000000 (b = 0x3F shifts by 31).
- ALU compare: SLT -1 vs 1 with u_s = 0 -> result 1, zero = 0. With u_s = 1 -> result 0, zero = 1. PASSB b = 0x12345000 -> 0x12345000.
- Branch flags: BEQ 3,3 -> zero = 1. BNE 3,3 -> zero = 0. BLT 0x80000000 vs 0 signed -> zero = 1, unsigned -> zero = 0. BGE 2,2 -> zero = 1.
- Random regression: random op/a/b against a reference model, plus random RF write/read sequences with a shadow array, 10k cycles with occasional async reset pulses.

Source files
------------

// File: rtl/rv32i_pkg.sv
`default_nettype none
// ============================================================================
// rv32i_pkg : shared constants for the RV32I PC / register file / ALU slice
// Revision  : 1.0
// ============================================================================
package rv32i_pkg;

    localparam int          XLEN             = 32;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    localparam logic [3:0] ALU_ADD   = 4'd0;
    localparam logic [3:0] ALU_SUB   = 4'd1;
    localparam logic [3:0] ALU_AND   = 4'd2;
    localparam logic [3:0] ALU_OR    = 4'd3;
    localparam logic [3:0] ALU_XOR   = 4'd4;
    localparam logic [3:0] ALU_SLL   = 4'd5;
    localparam logic [3:0] ALU_SRL   = 4'd6;
    localparam logic [3:0] ALU_SRA   = 4'd7;
    localparam logic [3:0] ALU_SLT   = 4'd8;
    localparam logic [3:0] ALU_PASSB = 4'd9;
    localparam logic [3:0] ALU_BEQ   = 4'd10;
    localparam logic [3:0] ALU_BNE   = 4'd11;
    localparam logic [3:0] ALU_BLT   = 4'd12;
    localparam logic [3:0] ALU_BGE   = 4'd13;

endpackage : rv32i_pkg
`default_nettype wire

// File: rtl/rv32i_regfile.sv
`default_nettype none
// ============================================================================
// rv32i_regfile : 32x32 register file, x0 hard-wired to zero, WB->ID bypass
// Revision      : 1.0
// ============================================================================
module rv32i_regfile #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            we,
    input  logic [4:0]      waddr,
    input  logic [XLEN-1:0] wdata,
    input  logic [4:0]      raddr1,
    input  logic [4:0]      raddr2,
    output logic [XLEN-1:0] rdata1,
    output logic [XLEN-1:0] rdata2
);

    // x0 has no storage; entries 1..31 only.
    logic [XLEN-1:0] r_regs [1:31];
    logic            w_wr_valid;

    assign w_wr_valid = we && (waddr != 5'd0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 1; i < 32; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_wr_valid) begin
            r_regs[waddr] <= wdata;
        end
    end

    // Bypass is gated by reset so reads stay zero while reset is held.
    always_comb begin
        rdata1 = '0;
        if (raddr1 != 5'd0) begin
            if (reset && w_wr_valid && (waddr == raddr1)) begin
                rdata1 = wdata;
            end else begin
                rdata1 = r_regs[raddr1];
            end
        end
    end

    always_comb begin
        rdata2 = '0;
        if (raddr2 != 5'd0) begin
            if (reset && w_wr_valid && (waddr == raddr2)) begin
                rdata2 = wdata;
            end else begin
                rdata2 = r_regs[raddr2];
            end
        end
    end

endmodule : rv32i_regfile
`default_nettype wire

// File: rtl/rv32i_pc_rf_alu.sv
`default_nettype none
// ============================================================================
// rv32i_pc_rf_alu : RV32I datapath primitives - PC register, register file, ALU
// Revision        : 1.0
// ============================================================================
module rv32i_pc_rf_alu #(
    parameter int          XLEN     = rv32i_pkg::XLEN,
    parameter logic [31:0] RESET_PC = rv32i_pkg::RESET_PC_DEFAULT
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            pc_stall,
    input  logic [XLEN-1:0] pc_next,
    output logic [XLEN-1:0] pc,
    input  logic            rf_we,
    input  logic [4:0]      rf_waddr,
    input  logic [XLEN-1:0] rf_wdata,
    input  logic [4:0]      rf_raddr1,
    input  logic [4:0]      rf_raddr2,
    output logic [XLEN-1:0] rf_rdata1,
    output logic [XLEN-1:0] rf_rdata2,
    input  logic [XLEN-1:0] alu_a,
    input  logic [XLEN-1:0] alu_b,
    input  logic [3:0]      alu_op,
    input  logic            alu_u_s,
    output logic [XLEN-1:0] alu_result,
    output logic            alu_zero
);

    import rv32i_pkg::*;

    logic [XLEN-1:0] r_pc;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pc <= RESET_PC;
        end else if (!pc_stall) begin
            r_pc <= pc_next;
        end
    end

    assign pc = r_pc;

    rv32i_regfile #(
        .XLEN (XLEN)
    ) u_regfile (
        .clk    (clk),
        .reset  (reset),
        .we     (rf_we),
        .waddr  (rf_waddr),
        .wdata  (rf_wdata),
        .raddr1 (rf_raddr1),
        .raddr2 (rf_raddr2),
        .rdata1 (rf_rdata1),
        .rdata2 (rf_rdata2)
    );

    logic [4:0]      w_shamt;
    logic            w_lt;
    logic            w_eq;
    logic [XLEN-1:0] w_diff;

    assign w_shamt = alu_b[4:0];
    assign w_diff  = alu_a - alu_b;
    assign w_eq    = (alu_a == alu_b);
    assign w_lt    = alu_u_s ? (alu_a < alu_b) : ($signed(alu_a) < $signed(alu_b));

    always_comb begin
        alu_result = '0;
        case (alu_op)
            ALU_ADD:   alu_result = alu_a + alu_b;
            ALU_SUB:   alu_result = w_diff;
            ALU_AND:   alu_result = alu_a & alu_b;
            ALU_OR:    alu_result = alu_a | alu_b;
            ALU_XOR:   alu_result = alu_a ^ alu_b;
            ALU_SLL:   alu_result = alu_a << w_shamt;
            ALU_SRL:   alu_result = alu_a >> w_shamt;
            ALU_SRA:   alu_result = $unsigned($signed(alu_a) >>> w_shamt);
            ALU_SLT:   alu_result = {{(XLEN-1){1'b0}}, w_lt};
            ALU_PASSB: alu_result = alu_b;
            ALU_BEQ:   alu_result = w_diff;
            ALU_BNE:   alu_result = w_diff;
            ALU_BLT:   alu_result = {{(XLEN-1){1'b0}}, w_lt};
            ALU_BGE:   alu_result = {{(XLEN-1){1'b0}}, ~w_lt};
            default:   alu_result = '0;
        endcase
    end

    // Branch ops report the condition itself; everything else reports result==0.
    always_comb begin
        alu_zero = (alu_result == '0);
        case (alu_op)
            ALU_BEQ: alu_zero = w_eq;
            ALU_BNE: alu_zero = ~w_eq;
            ALU_BLT: alu_zero = w_lt;
            ALU_BGE: alu_zero = ~w_lt;
            default: alu_zero = (alu_result == '0);
        endcase
    end

endmodule : rv32i_pc_rf_alu
`default_nettype wire

// File: tb/tb_rv32i_pc_rf_alu.sv
`default_nettype none
// ============================================================================
// tb_rv32i_pc_rf_alu : directed + randomized self-checking bench
// Revision           : 1.0
// ============================================================================
module tb_rv32i_pc_rf_alu;

    logic        clk;
    logic        reset;
    logic        pc_stall;
    logic [31:0] pc_next;
    logic [31:0] pc;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic [4:0]  rf_raddr1;
    logic [4:0]  rf_raddr2;
    logic [31:0] rf_rdata1;
    logic [31:0] rf_rdata2;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [3:0]  alu_op;
    logic        alu_u_s;
    logic [31:0] alu_result;
    logic        alu_zero;

    int tests;
    int fails;

    rv32i_pc_rf_alu #(
        .XLEN     (32),
        .RESET_PC (32'h0000_0000)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .pc_stall   (pc_stall),
        .pc_next    (pc_next),
        .pc         (pc),
        .rf_we      (rf_we),
        .rf_waddr   (rf_waddr),
        .rf_wdata   (rf_wdata),
        .rf_raddr1  (rf_raddr1),
        .rf_raddr2  (rf_raddr2),
        .rf_rdata1  (rf_rdata1),
        .rf_rdata2  (rf_rdata2),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_op     (alu_op),
        .alu_u_s    (alu_u_s),
        .alu_result (alu_result),
        .alu_zero   (alu_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference ALU: returns {zero, result}
    function automatic logic [32:0] alu_ref(input logic [3:0] op, input logic [31:0] a,
                                            input logic [31:0] b, input logic us);
        logic [31:0] r;
        logic        z;
        logic        lt;
        lt = us ? (a < b) : ($signed(a) < $signed(b));
        r  = 32'h0;
        case (op)
            4'd0:  r = a + b;
            4'd1:  r = a - b;
            4'd2:  r = a & b;
            4'd3:  r = a | b;
            4'd4:  r = a ^ b;
            4'd5:  r = a << b[4:0];
            4'd6:  r = a >> b[4:0];
            4'd7:  r = $unsigned($signed(a) >>> b[4:0]);
            4'd8:  r = {31'b0, lt};
            4'd9:  r = b;
            4'd10: r = a - b;
            4'd11: r = a - b;
            4'd12: r = {31'b0, lt};
            4'd13: r = {31'b0, !lt};
            default: r = 32'h0;
        endcase
        case (op)
            4'd10:   z = (a == b);
            4'd11:   z = (a != b);
            4'd12:   z = lt;
            4'd13:   z = !lt;
            default: z = (r == 32'h0);
        endcase
        return {z, r};
    endfunction

    task automatic test_reset();
        reset = 1'b0; pc_stall = 1'b0; pc_next = 32'h40;
        rf_we = 1'b0; rf_waddr = 5'd0; rf_wdata = 32'h0; rf_raddr1 = 5'd3; rf_raddr2 = 5'd31;
        alu_a = 32'h0; alu_b = 32'h0; alu_op = 4'd0; alu_u_s = 1'b0;
        #1;
        tests++;
        if (pc !== 32'h0) begin
            fails++; $display("FAIL reset_pc: got %h expected %h", pc, 32'h0);
        end
        tests++;
        if (rf_rdata1 !== 32'h0 || rf_rdata2 !== 32'h0) begin
            fails++; $display("FAIL reset_rf: got %h/%h expected 0/0", rf_rdata1, rf_rdata2);
        end
    endtask

    task automatic test_pc();
        @(negedge clk); reset = 1'b1; pc_stall = 1'b0; pc_next = 32'h40;
        @(posedge clk); #1;
        tests++;
        if (pc !== 32'h40) begin
            fails++; $display("FAIL pc_load: got %h expected %h", pc, 32'h40);
        end
        @(negedge clk); pc_stall = 1'b1; pc_next = 32'h80;
        @(posedge clk); #1;
        tests++;
        if (pc !== 32'h40) begin
            fails++; $display("FAIL pc_stall: got %h expected %h", pc, 32'h40);
        end
        @(negedge clk); #1; reset = 1'b0; #1;
        tests++;
        if (pc !== 32'h0) begin
            fails++; $display("FAIL pc_async_reset: got %h expected %h", pc, 32'h0);
        end
        @(negedge clk); reset = 1'b1; pc_stall = 1'b0; pc_next = 32'h0000_0103;
        @(posedge clk); #1;
        tests++;
        if (pc !== 32'h0000_0103) begin
            fails++; $display("FAIL pc_unaligned: got %h expected %h", pc, 32'h0000_0103);
        end
    endtask

    task automatic test_rf();
        @(negedge clk); pc_stall = 1'b1;
        rf_we = 1'b1; rf_waddr = 5'd5; rf_wdata = 32'hDEAD_BEEF; rf_raddr1 = 5'd1; rf_raddr2 = 5'd1;
        @(posedge clk);
        @(negedge clk); rf_we = 1'b0; rf_raddr1 = 5'd5; rf_raddr2 = 5'd5; #1;
        tests++;
        if (rf_rdata1 !== 32'hDEAD_BEEF || rf_rdata2 !== 32'hDEAD_BEEF) begin
            fails++; $display("FAIL rf_write_read: got %h/%h expected %h", rf_rdata1, rf_rdata2, 32'hDEAD_BEEF);
        end
        @(negedge clk); rf_we = 1'b1; rf_waddr = 5'd0; rf_wdata = 32'h1234; rf_raddr1 = 5'd0; rf_raddr2 = 5'd0; #1;
        tests++;
        if (rf_rdata1 !== 32'h0 || rf_rdata2 !== 32'h0) begin
            fails++; $display("FAIL rf_x0_bypass: got %h/%h expected 0/0", rf_rdata1, rf_rdata2);
        end
        @(posedge clk);
        @(negedge clk); rf_we = 1'b0; #1;
        tests++;
        if (rf_rdata1 !== 32'h0) begin
            fails++; $display("FAIL rf_x0_write: got %h expected 0", rf_rdata1);
        end
        @(negedge clk); rf_we = 1'b1; rf_waddr = 5'd7; rf_wdata = 32'hA5A5_A5A5;
        rf_raddr1 = 5'd7; rf_raddr2 = 5'd5; #1;
        tests++;
        if (rf_rdata1 !== 32'hA5A5_A5A5 || rf_rdata2 !== 32'hDEAD_BEEF) begin
            fails++; $display("FAIL rf_bypass: got %h/%h expected a5a5a5a5/deadbeef", rf_rdata1, rf_rdata2);
        end
        @(posedge clk);
        @(negedge clk); rf_we = 1'b0; rf_raddr1 = 5'd5; rf_raddr2 = 5'd7; #1; reset = 1'b0; #1;
        tests++;
        if (rf_rdata1 !== 32'h0 || rf_rdata2 !== 32'h0) begin
            fails++; $display("FAIL rf_reset_clear: got %h/%h expected 0/0", rf_rdata1, rf_rdata2);
        end
        @(negedge clk); reset = 1'b1;
    endtask

    task automatic check_alu(input string name, input logic [3:0] op, input logic [31:0] a,
                             input logic [31:0] b, input logic us,
                             input logic [31:0] exp_r, input logic exp_z);
        alu_op = op; alu_a = a; alu_b = b; alu_u_s = us; #1;
        tests++;
        if (alu_result !== exp_r || alu_zero !== exp_z) begin
            fails++;
            $display("FAIL %s: got result %h zero %b expected result %h zero %b",
                     name, alu_result, alu_zero, exp_r, exp_z);
        end
    endtask

    task automatic test_alu_arith();
        check_alu("add_wrap", 4'd0, 32'hFFFF_FFFF, 32'h1, 1'b0, 32'h0, 1'b1);
        check_alu("sub_neg",  4'd1, 32'd5, 32'd7, 1'b0, 32'hFFFF_FFFE, 1'b0);
        check_alu("sra",      4'd7, 32'h8000_0000, 32'd4, 1'b0, 32'hF800_0000, 1'b0);
        check_alu("srl",      4'd6, 32'h8000_0000, 32'd4, 1'b0, 32'h0800_0000, 1'b0);
        check_alu("sll_mask", 4'd5, 32'h1, 32'h3F, 1'b0, 32'h8000_0000, 1'b0);
        check_alu("and",      4'd2, 32'hF0F0_FFFF, 32'h0FF0_1234, 1'b0, 32'h00F0_1234, 1'b0);
        check_alu("or",       4'd3, 32'hF000_0000, 32'h0000_000F, 1'b0, 32'hF000_000F, 1'b0);
        check_alu("xor_self", 4'd4, 32'h1357_9BDF, 32'h1357_9BDF, 1'b0, 32'h0, 1'b1);
        check_alu("reserved", 4'd14, 32'h5, 32'h6, 1'b0, 32'h0, 1'b1);
    endtask

    task automatic test_alu_cmp();
        check_alu("slt_signed",   4'd8, 32'hFFFF_FFFF, 32'h1, 1'b0, 32'h1, 1'b0);
        check_alu("slt_unsigned", 4'd8, 32'hFFFF_FFFF, 32'h1, 1'b1, 32'h0, 1'b1);
        check_alu("passb",        4'd9, 32'hDEAD_0000, 32'h1234_5000, 1'b0, 32'h1234_5000, 1'b0);
        check_alu("add_us_ignored", 4'd0, 32'h2, 32'h3, 1'b1, 32'h5, 1'b0);
    endtask

    task automatic test_branch();
        check_alu("beq_taken",   4'd10, 32'd3, 32'd3, 1'b0, 32'h0, 1'b1);
        check_alu("bne_not",     4'd11, 32'd3, 32'd3, 1'b0, 32'h0, 1'b0);
        check_alu("bne_taken",   4'd11, 32'd3, 32'd1, 1'b0, 32'h2, 1'b1);
        check_alu("blt_signed",  4'd12, 32'h8000_0000, 32'h0, 1'b0, 32'h1, 1'b1);
        check_alu("blt_unsigned",4'd12, 32'h8000_0000, 32'h0, 1'b1, 32'h0, 1'b0);
        check_alu("bge_equal",   4'd13, 32'd2, 32'd2, 1'b0, 32'h1, 1'b1);
        check_alu("bge_less",    4'd13, 32'd1, 32'd2, 1'b1, 32'h0, 1'b0);
    endtask

    task automatic test_random_alu();
        logic [32:0] exp;
        int          bad;
        bad = 0;
        for (int i = 0; i < 10000; i++) begin
            alu_op  = 4'($urandom_range(0, 15));
            alu_a   = (i % 7 == 0) ? 32'h8000_0000 : $urandom;
            alu_b   = (i % 11 == 0) ? alu_a : ((i % 13 == 0) ? 32'hFFFF_FFFF : $urandom);
            alu_u_s = 1'($urandom_range(0, 1));
            #1;
            exp = alu_ref(alu_op, alu_a, alu_b, alu_u_s);
            tests++;
            if ({alu_zero, alu_result} !== exp) begin
                fails++;
                if (bad < 10) begin
                    $display("FAIL rand_alu op=%0d a=%h b=%h us=%b: got %b/%h expected %b/%h",
                             alu_op, alu_a, alu_b, alu_u_s, alu_zero, alu_result, exp[32], exp[31:0]);
                end
                bad++;
            end
        end
    endtask

    task automatic test_random_rf_pc();
        logic [31:0] shadow [32];
        logic [31:0] pc_model;
        logic [31:0] e1;
        logic [31:0] e2;
        int          bad;
        bad = 0;
        for (int k = 0; k < 32; k++) shadow[k] = 32'h0;
        // A reset was asserted at the end of test_rf; state is cleared, pc = 0x0.
        pc_model = 32'h0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if ($urandom_range(0, 199) == 0) begin
                rf_we = 1'b1; rf_waddr = 5'd9; rf_wdata = 32'hCAFE_F00D;
                rf_raddr1 = 5'd9; rf_raddr2 = 5'd3;
                #1; reset = 1'b0; #1;
                for (int k = 0; k < 32; k++) shadow[k] = 32'h0;
                pc_model = 32'h0;
                tests++;
                if (pc !== 32'h0 || rf_rdata1 !== 32'h0 || rf_rdata2 !== 32'h0) begin
                    fails++;
                    $display("FAIL rand_reset: got pc %h rd %h/%h expected 0/0/0", pc, rf_rdata1, rf_rdata2);
                end
                reset = 1'b1;
            end
            rf_we     = 1'($urandom_range(0, 1));
            rf_waddr  = 5'($urandom_range(0, 31));
            rf_wdata  = $urandom;
            rf_raddr1 = ($urandom_range(0, 3) == 0) ? rf_waddr : 5'($urandom_range(0, 31));
            rf_raddr2 = ($urandom_range(0, 3) == 0) ? rf_raddr1 : 5'($urandom_range(0, 31));
            pc_stall  = 1'($urandom_range(0, 3) == 0);
            pc_next   = $urandom;
            #1;
            e1 = (rf_raddr1 == 5'd0) ? 32'h0 :
                 (rf_we && rf_waddr != 5'd0 && rf_waddr == rf_raddr1) ? rf_wdata : shadow[rf_raddr1];
            e2 = (rf_raddr2 == 5'd0) ? 32'h0 :
                 (rf_we && rf_waddr != 5'd0 && rf_waddr == rf_raddr2) ? rf_wdata : shadow[rf_raddr2];
            tests++;
            if (rf_rdata1 !== e1 || rf_rdata2 !== e2 || pc !== pc_model) begin
                fails++;
                if (bad < 10) begin
                    $display("FAIL rand_rf_pc cyc=%0d: got rd %h/%h pc %h expected %h/%h pc %h",
                             i, rf_rdata1, rf_rdata2, pc, e1, e2, pc_model);
                end
                bad++;
            end
            @(posedge clk);
            if (rf_we && rf_waddr != 5'd0) shadow[rf_waddr] = rf_wdata;
            if (!pc_stall) pc_model = pc_next;
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        test_reset();
        test_pc();
        test_rf();
        test_alu_arith();
        test_alu_cmp();
        test_branch();
        test_random_alu();
        test_random_rf_pc();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule : tb_rv32i_pc_rf_alu
`default_nettype wire
